// File: rtl/imm_gen_pipe.sv
// RISC-V decode-stage immediate generator. It decodes the immediate, format, legality
// and PC-relative target, then buffers each result in a 2-entry in-order FIFO.
module imm_gen_pipe #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              insn_valid_i,
    output logic              insn_ready_o,
    input  logic [31:0]       insn_i,
    input  logic [AWIDTH-1:0] pc_i,
    output logic              imm_valid_o,
    input  logic              imm_ready_i,
    output logic [DWIDTH-1:0] imm_o,
    output logic [2:0]        fmt_o,
    output logic [AWIDTH-1:0] target_o,
    output logic [31:0]       insn_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic              illegal_o
);
    localparam bit RV64 = (DWIDTH == 64);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    typedef struct packed {
        logic [DWIDTH-1:0] imm;
        logic [2:0]        fmt;
        logic [AWIDTH-1:0] target;
        logic [31:0]       insn;
        logic [AWIDTH-1:0] pc;
        logic              illegal;
    } entry_t;

    logic [DWIDTH-1:0] imm_s;
    logic [2:0]        fmt_s;
    logic              illegal_s;
    logic              pc_rel_s;
    logic              shift_f3_s;
    logic              shamt_ok_s;
    logic [AWIDTH-1:0] target_s;
    entry_t            wr_entry_s;
    entry_t            head_s;

    entry_t            mem_q [2];
    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              push_s, pop_s;

    // Combinational decode of the offered instruction
    always_comb begin
        imm_s      = '0;
        fmt_s      = FMT_NONE;
        illegal_s  = 1'b1;
        pc_rel_s   = 1'b0;
        shift_f3_s = (insn_i[14:12] == 3'b001) || (insn_i[14:12] == 3'b101);
        // RV64 shamt takes bit 25, so only bits [31:26] are checked there
        if (RV64) begin
            shamt_ok_s = (insn_i[31:26] == 6'b000000) || (insn_i[31:26] == 6'b010000);
        end else begin
            shamt_ok_s = (insn_i[31:25] == 7'b0000000) || (insn_i[31:25] == 7'b0100000);
        end
        if (insn_i[1:0] == 2'b11) begin
            case (insn_i[6:0])
                OPC_OP_IMM, OPC_OP_IMM_32: begin
                    if ((insn_i[6:0] == OPC_OP_IMM_32) && !RV64) begin
                        illegal_s = 1'b1;
                    end else if (shift_f3_s) begin
                        if (shamt_ok_s) begin
                            fmt_s     = FMT_SHAMT;
                            illegal_s = 1'b0;
                            if (RV64 && (insn_i[6:0] == OPC_OP_IMM)) begin
                                imm_s = DWIDTH'(insn_i[25:20]);
                            end else begin
                                imm_s = DWIDTH'(insn_i[24:20]);
                            end
                        end else begin
                            illegal_s = 1'b1;
                        end
                    end else begin
                        fmt_s     = FMT_I;
                        illegal_s = 1'b0;
                        imm_s     = DWIDTH'(signed'(insn_i[31:20]));
                    end
                end
                OPC_LOAD, OPC_JALR: begin
                    fmt_s     = FMT_I;
                    illegal_s = 1'b0;
                    imm_s     = DWIDTH'(signed'(insn_i[31:20]));
                end
                OPC_STORE: begin
                    fmt_s     = FMT_S;
                    illegal_s = 1'b0;
                    imm_s     = DWIDTH'(signed'({insn_i[31:25], insn_i[11:7]}));
                end
                OPC_BRANCH: begin
                    fmt_s     = FMT_B;
                    illegal_s = 1'b0;
                    pc_rel_s  = 1'b1;
                    imm_s     = DWIDTH'(signed'({insn_i[31], insn_i[7], insn_i[30:25],
                                                 insn_i[11:8], 1'b0}));
                end
                OPC_LUI, OPC_AUIPC: begin
                    fmt_s     = FMT_U;
                    illegal_s = 1'b0;
                    pc_rel_s  = (insn_i[6:0] == OPC_AUIPC);
                    imm_s     = DWIDTH'(signed'({insn_i[31:12], 12'd0}));
                end
                OPC_JAL: begin
                    fmt_s     = FMT_J;
                    illegal_s = 1'b0;
                    pc_rel_s  = 1'b1;
                    imm_s     = DWIDTH'(signed'({insn_i[31], insn_i[19:12], insn_i[20],
                                                 insn_i[30:21], 1'b0}));
                end
                default: begin
                    illegal_s = 1'b1;
                end
            endcase
        end else begin
            illegal_s = 1'b1;
        end
    end

    assign target_s   = pc_rel_s ? (pc_i + imm_s[AWIDTH-1:0]) : pc_i;
    assign wr_entry_s = '{imm: imm_s, fmt: fmt_s, target: target_s, insn: insn_i,
                          pc: pc_i, illegal: illegal_s};

    assign insn_ready_o = (count_q != 2'd2);
    assign imm_valid_o  = (count_q != 2'd0);
    assign push_s       = insn_valid_i && insn_ready_o && !flush_i;
    assign pop_s        = imm_valid_o && imm_ready_i && !flush_i;

    // FIFO pointer and occupancy next-state; flush wins over push and pop
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            wr_ptr_d = push_s ? ~wr_ptr_q : wr_ptr_q;
            rd_ptr_d = pop_s ? ~rd_ptr_q : rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state registers and entry storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= wr_entry_s;
            end
        end
    end

    assign head_s    = imm_valid_o ? mem_q[rd_ptr_q] : '0;
    assign imm_o     = head_s.imm;
    assign fmt_o     = head_s.fmt;
    assign target_o  = head_s.target;
    assign insn_o    = head_s.insn;
    assign pc_o      = head_s.pc;
    assign illegal_o = head_s.illegal;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed vector table, multi-cycle corner
// sequences and a randomized stream against a queue-based reference model (RV32 and RV64).
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush_i, insn_valid_i, imm_ready_i;
    logic [31:0] insn_i, pc_i;

    logic        rdy32, v32, ill32;
    logic [31:0] imm32, tgt32, insn32, pc32;
    logic [2:0]  fmt32;
    logic        rdy64, v64, ill64;
    logic [63:0] imm64;
    logic [31:0] tgt64, insn64, pc64;
    logic [2:0]  fmt64;

    imm_gen_pipe #(.DWIDTH(32), .AWIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .flush_i(flush_i), .insn_valid_i(insn_valid_i),
        .insn_ready_o(rdy32), .insn_i(insn_i), .pc_i(pc_i), .imm_valid_o(v32),
        .imm_ready_i(imm_ready_i), .imm_o(imm32), .fmt_o(fmt32), .target_o(tgt32),
        .insn_o(insn32), .pc_o(pc32), .illegal_o(ill32));

    imm_gen_pipe #(.DWIDTH(64), .AWIDTH(32)) dut64 (
        .clk(clk), .reset(reset), .flush_i(flush_i), .insn_valid_i(insn_valid_i),
        .insn_ready_o(rdy64), .insn_i(insn_i), .pc_i(pc_i), .imm_valid_o(v64),
        .imm_ready_i(imm_ready_i), .imm_o(imm64), .fmt_o(fmt64), .target_o(tgt64),
        .insn_o(insn64), .pc_o(pc64), .illegal_o(ill64));

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tgt;
        logic [31:0] insn;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
        bit          rv64;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tgt;
        logic        ill;
    } vec_t;

    exp_t q32[$];
    exp_t q64[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode from the instruction-set rules, using signed arithmetic on fields
    function automatic exp_t ref_decode(logic [31:0] w, logic [31:0] pc, bit rv64);
        exp_t       e;
        longint     v = 0;
        int         fmt = 0;
        bit         ill = 0;
        bit         rel = 0;
        int         f3, top;
        logic [6:0] opc;
        logic [63:0] vb;
        opc = w[6:0];
        f3  = int'(w[14:12]);
        if (w[1:0] != 2'b11) ill = 1;
        else if (opc == 7'b0010011 || (opc == 7'b0011011 && rv64)) begin
            if (f3 == 1 || f3 == 5) begin
                top = rv64 ? int'(w[31:26]) : int'(w[31:25]);
                if (top != 0 && top != (rv64 ? 16 : 32)) ill = 1;
                fmt = 6;
                v = (rv64 && opc == 7'b0010011) ? longint'(w[25:20]) : longint'(w[24:20]);
            end else begin
                fmt = 1;
                v = longint'(w[31:20]) - (w[31] ? 4096 : 0);
            end
        end else if (opc == 7'b0000011 || opc == 7'b1100111) begin
            fmt = 1;
            v = longint'(w[31:20]) - (w[31] ? 4096 : 0);
        end else if (opc == 7'b0100011) begin
            fmt = 2;
            v = longint'(w[31:25]) * 32 + longint'(w[11:7]) - (w[31] ? 4096 : 0);
        end else if (opc == 7'b1100011) begin
            fmt = 3; rel = 1;
            v = longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2 + (w[7] ? 2048 : 0)
                - (w[31] ? 4096 : 0);
        end else if (opc == 7'b0110111 || opc == 7'b0010111) begin
            fmt = 4; rel = (opc == 7'b0010111);
            v = longint'(w[31:12]) * 4096 - (w[31] ? 64'sd4294967296 : 64'sd0);
        end else if (opc == 7'b1101111) begin
            fmt = 5; rel = 1;
            v = longint'(w[30:21]) * 2 + (w[20] ? 2048 : 0) + longint'(w[19:12]) * 4096
                - (w[31] ? 1048576 : 0);
        end else ill = 1;
        if (ill) begin fmt = 0; v = 0; rel = 0; end
        vb     = v;
        e.imm  = rv64 ? vb : {32'd0, vb[31:0]};
        e.fmt  = fmt[2:0];
        e.tgt  = rel ? pc + vb[31:0] : pc;
        e.insn = w;
        e.pc   = pc;
        e.ill  = ill;
        return e;
    endfunction

    task automatic chk_dut(string tag, input exp_t q[$], logic v, logic r, logic [63:0] imm,
                           logic [2:0] fmt, logic [31:0] tgt, logic [31:0] insn,
                           logic [31:0] pc, logic ill);
        exp_t e;
        e = (q.size() > 0) ? q[0] : '0;
        chk({tag, "_valid"}, v, q.size() > 0);
        chk({tag, "_ready"}, r, q.size() < 2);
        chk({tag, "_imm"}, imm, e.imm);
        chk({tag, "_fmt"}, fmt, e.fmt);
        chk({tag, "_target"}, tgt, e.tgt);
        chk({tag, "_insn"}, insn, e.insn);
        chk({tag, "_pc"}, pc, e.pc);
        chk({tag, "_illegal"}, ill, e.ill);
    endtask

    task automatic check_outputs();
        chk_dut("d32", q32, v32, rdy32, {32'd0, imm32}, fmt32, tgt32, insn32, pc32, ill32);
        chk_dut("d64", q64, v64, rdy64, imm64, fmt64, tgt64, insn64, pc64, ill64);
    endtask

    // One clock: update the model from the inputs seen at the edge, then check at negedge
    task automatic cycle();
        int s32, s64;
        s32 = q32.size();
        s64 = q64.size();
        @(posedge clk);
        if (flush_i) begin
            q32.delete();
            q64.delete();
        end else begin
            if (imm_ready_i && s32 > 0) void'(q32.pop_front());
            if (imm_ready_i && s64 > 0) void'(q64.pop_front());
            if (insn_valid_i && s32 < 2) q32.push_back(ref_decode(insn_i, pc_i, 1'b0));
            if (insn_valid_i && s64 < 2) q64.push_back(ref_decode(insn_i, pc_i, 1'b1));
        end
        @(negedge clk);
        check_outputs();
    endtask

    vec_t        tbl [15];
    logic [31:0] got[$];
    logic [31:0] seq [3];
    logic [6:0]  ops [10];
    logic [31:0] r;
    bit          accepted;

    initial begin
        tbl[0]  = '{32'hFFF00093, 32'h00000100, 1'b0, 64'hFFFFFFFF, 3'd1, 32'h00000100, 1'b0};
        tbl[1]  = '{32'hFE20EEE3, 32'h00000200, 1'b0, 64'hFFFFFFFC, 3'd3, 32'h000001FC, 1'b0};
        tbl[2]  = '{32'h4030D093, 32'h00000040, 1'b0, 64'h3,        3'd6, 32'h00000040, 1'b0};
        tbl[3]  = '{32'h4230D093, 32'h00000040, 1'b0, 64'h0,        3'd0, 32'h00000040, 1'b1};
        tbl[4]  = '{32'h0200006F, 32'hFFFFFFF0, 1'b0, 64'h20,       3'd5, 32'h00000010, 1'b0};
        tbl[5]  = '{32'h800000B7, 32'h00000000, 1'b0, 64'h80000000, 3'd4, 32'h00000000, 1'b0};
        tbl[6]  = '{32'h00001097, 32'h00001000, 1'b0, 64'h1000,     3'd4, 32'h00002000, 1'b0};
        tbl[7]  = '{32'hFE20AC23, 32'h00000300, 1'b0, 64'hFFFFFFF8, 3'd2, 32'h00000300, 1'b0};
        tbl[8]  = '{32'h00000010, 32'h00000050, 1'b0, 64'h0,        3'd0, 32'h00000050, 1'b1};
        tbl[9]  = '{32'h7FF0809B, 32'h00000060, 1'b0, 64'h0,        3'd0, 32'h00000060, 1'b1};
        tbl[10] = '{32'h800000B7, 32'h00000000, 1'b1, 64'hFFFFFFFF80000000, 3'd4, 32'h0, 1'b0};
        tbl[11] = '{32'h7FF0809B, 32'h00000060, 1'b1, 64'h7FF,      3'd1, 32'h00000060, 1'b0};
        tbl[12] = '{32'h4230D093, 32'h00000070, 1'b1, 64'h23,       3'd6, 32'h00000070, 1'b0};
        tbl[13] = '{32'h4430D093, 32'h00000070, 1'b1, 64'h0,        3'd0, 32'h00000070, 1'b1};
        tbl[14] = '{32'h0000007F, 32'h00000080, 1'b0, 64'h0,        3'd0, 32'h00000080, 1'b1};
        ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h13};
        seq = '{32'hFFF00093, 32'hFE20EEE3, 32'h0200006F};

        reset = 1'b1; flush_i = 1'b0; insn_valid_i = 1'b0; imm_ready_i = 1'b0;
        insn_i = 32'h0; pc_i = 32'h0;
        #3;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cycle();

        // Directed table: accept one instruction, expect it at the head one cycle later
        foreach (tbl[i]) begin
            insn_i = tbl[i].insn; pc_i = tbl[i].pc; insn_valid_i = 1'b1; imm_ready_i = 1'b0;
            cycle();
            if (tbl[i].rv64) begin
                chk("tbl_valid", v64, 1'b1);
                chk("tbl_imm", imm64, tbl[i].imm);
                chk("tbl_fmt", fmt64, tbl[i].fmt);
                chk("tbl_target", tgt64, tbl[i].tgt);
                chk("tbl_illegal", ill64, tbl[i].ill);
            end else begin
                chk("tbl_valid", v32, 1'b1);
                chk("tbl_imm", {32'd0, imm32}, tbl[i].imm);
                chk("tbl_fmt", fmt32, tbl[i].fmt);
                chk("tbl_target", tgt32, tbl[i].tgt);
                chk("tbl_illegal", ill32, tbl[i].ill);
            end
            insn_valid_i = 1'b0; imm_ready_i = 1'b1;
            cycle();
        end

        // Backpressure: three offered with the sink stalled, then drained in order
        imm_ready_i = 1'b0; insn_valid_i = 1'b1; pc_i = 32'h00000400;
        insn_i = seq[0]; cycle();
        insn_i = seq[1]; cycle();
        chk("bp_ready_low", rdy32, 1'b0);
        insn_i = seq[2]; cycle();
        chk("bp_head_stable", insn32, seq[0]);
        cycle();
        chk("bp_head_stable2", insn32, seq[0]);
        chk("bp_still_full", rdy32, 1'b0);
        imm_ready_i = 1'b1;
        for (int k = 0; k < 10 && got.size() < 3; k++) begin
            if (v32 && imm_ready_i) got.push_back(insn32);
            accepted = insn_valid_i && rdy32;
            cycle();
            if (accepted) insn_valid_i = 1'b0;
        end
        insn_valid_i = 1'b0;
        chk("bp_count", got.size(), 3);
        for (int k = 0; k < 3; k++) chk("bp_order", (got.size() > k) ? got[k] : 32'hDEADBEEF, seq[k]);

        // Flush with two queued, and with one queued, each with a competing push
        imm_ready_i = 1'b0; insn_valid_i = 1'b1;
        insn_i = seq[0]; cycle();
        insn_i = seq[1]; cycle();
        flush_i = 1'b1; insn_i = seq[2]; cycle();
        chk("flush_valid", v32, 1'b0);
        chk("flush_ready", rdy32, 1'b1);
        flush_i = 1'b0; insn_valid_i = 1'b0; cycle();
        chk("flush_no_push", v32, 1'b0);
        insn_valid_i = 1'b1; insn_i = seq[0]; cycle();
        flush_i = 1'b1; insn_i = seq[1]; imm_ready_i = 1'b1; cycle();
        flush_i = 1'b0; insn_valid_i = 1'b0; cycle();
        chk("flush1_no_push", v64, 1'b0);

        // Asynchronous reset between clock edges with two entries in flight
        imm_ready_i = 1'b0; insn_valid_i = 1'b1;
        insn_i = seq[1]; cycle();
        insn_i = seq[2]; cycle();
        insn_valid_i = 1'b0;
        #2 reset = 1'b1;
        #1;
        q32.delete();
        q64.delete();
        chk("rst_async_valid", v32, 1'b0);
        chk("rst_async_ready", rdy64, 1'b1);
        chk("rst_async_imm", imm64, 64'd0);
        chk("rst_async_insn", insn32, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cycle();

        // Randomized stream with random handshakes and occasional flush
        for (int n = 0; n < 1500; n++) begin
            r = $urandom();
            insn_i = $urandom();
            if (r[3:0] < 4'd12) insn_i[6:0] = ops[r[7:4] % 10];
            if (r[9:8] == 2'b00) insn_i[31:25] = {1'b0, r[10], 4'b0000, r[11]};
            pc_i = $urandom();
            insn_valid_i = (r[13:12] != 2'b00);
            imm_ready_i  = (r[15:14] != 2'b00);
            flush_i      = (r[21:16] == 6'd0);
            cycle();
        end
        flush_i = 1'b0; insn_valid_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
